// File: rtl/branch_target_assoc.sv
// branch_target_assoc
// Set-associative branch target buffer for the fetch stage.
//   - Fetch lookup of PC is purely combinational (Hit, Pred_Taken, Target_Add).
//   - Branches resolved in Ex (PC_Ex, PC_ALU, Br_Update, Br_Detected) are
//     written back at the rising edge of clk, with true-LRU replacement.
//   - rst is synchronous and active high; while it is high the outputs show a
//     miss (Target_Add = PC + 4).
// Ports:
//   clk, rst                  clock and synchronous reset
//   PC                        fetch address to look up
//   PC_Ex, PC_ALU             resolving branch address and its resolved target
//   Br_Update, Br_Detected    resolve strobe and direction (1 = taken)
//   Hit, Pred_Taken, Target_Add  lookup results
// Optional feature: define BTB_2BIT_COUNTER_EN to add 2-bit direction counters
// per entry. Without it, a not-taken resolve of a hit entry invalidates it.
module branch_target_assoc #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int WIDTH_ENTRY_LENTH = 3,
    parameter int WAYS              = 2,
    parameter int WIDTH_TAG_LENGTH  = WIDTH_DATA_LENGTH - 2 - WIDTH_ENTRY_LENTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_Ex,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
    input  logic                         Br_Update,
    input  logic                         Br_Detected,
    output logic                         Hit,
    output logic                         Pred_Taken,
    output logic [WIDTH_DATA_LENGTH-1:0] Target_Add
);

    localparam int SETS  = 1 << WIDTH_ENTRY_LENTH;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_W = AGE_W;

`ifdef BTB_2BIT_COUNTER_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    // Entry and replacement state
    logic                         valid_reg  [SETS][WAYS];
    logic [WIDTH_TAG_LENGTH-1:0]  tag_reg    [SETS][WAYS];
    logic [WIDTH_DATA_LENGTH-1:0] target_reg [SETS][WAYS];
    logic [AGE_W-1:0]             age_reg    [SETS][WAYS];
`ifdef BTB_2BIT_COUNTER_EN
    logic [1:0]                   ctr_reg    [SETS][WAYS];
`endif

    // Address split; bits [1:0] play no part in the lookup
    logic [WIDTH_ENTRY_LENTH-1:0] fetch_idx, ex_idx;
    logic [WIDTH_TAG_LENGTH-1:0]  fetch_tag, ex_tag;
    logic                         unused_addr_bits;

    assign fetch_idx = PC[WIDTH_ENTRY_LENTH+1:2];
    assign ex_idx    = PC_Ex[WIDTH_ENTRY_LENTH+1:2];
    assign fetch_tag = PC[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2];
    assign ex_tag    = PC_Ex[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2];
    assign unused_addr_bits = ^{PC[1:0], PC_Ex[1:0]};

    // Per-way match vectors for both ports
    logic [WAYS-1:0] hit_vec, ex_hit_vec, ex_valid_vec, lru_vec;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign hit_vec[gi]      = valid_reg[fetch_idx][gi] && (tag_reg[fetch_idx][gi] == fetch_tag);
            assign ex_hit_vec[gi]   = valid_reg[ex_idx][gi] && (tag_reg[ex_idx][gi] == ex_tag);
            assign ex_valid_vec[gi] = valid_reg[ex_idx][gi];
            assign lru_vec[gi]      = (age_reg[ex_idx][gi] == AGE_W'(WAYS - 1));
        end
    endgenerate

    // Fetch-side read mux; at most one way can match, so OR-combining is exact
    logic [WIDTH_DATA_LENGTH-1:0] hit_target;
    logic                         hit_ctr_msb;
    logic                         lookup_hit;

    always_comb begin
        hit_target  = '0;
        hit_ctr_msb = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_target = hit_target | target_reg[fetch_idx][w];
`ifdef BTB_2BIT_COUNTER_EN
                hit_ctr_msb = hit_ctr_msb | ctr_reg[fetch_idx][w][1];
`endif
            end
        end
    end

    assign lookup_hit = |hit_vec;
    assign Hit        = !rst && lookup_hit;
    assign Pred_Taken = CTR_EN ? (Hit && hit_ctr_msb) : Hit;
    assign Target_Add = Hit ? hit_target : (PC + WIDTH_DATA_LENGTH'(4));

    // Ex-side way selection
    logic             ex_hit;
    logic [WAY_W-1:0] ex_hit_way, victim_way, touched_way;
    logic [AGE_W-1:0] touched_age;
    logic             touch_en;

    always_comb begin
        ex_hit_way = '0;
        victim_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ex_hit_vec[w]) ex_hit_way = WAY_W'(w);
            if (lru_vec[w])    victim_way = WAY_W'(w);
        end
        // A free way always beats evicting the LRU one; lowest index wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!ex_valid_vec[w]) victim_way = WAY_W'(w);
        end
    end

    assign ex_hit      = |ex_hit_vec;
    assign touched_way = ex_hit ? ex_hit_way : victim_way;
    assign touched_age = age_reg[ex_idx][touched_way];
    // Not-taken resolves only refresh recency when the entry survives them
    assign touch_en    = Br_Update && (Br_Detected || (ex_hit && CTR_EN));

    // Entry write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
`ifdef BTB_2BIT_COUNTER_EN
                    ctr_reg[s][w]   <= 2'd2;
`endif
                end
            end
        end else if (Br_Update) begin
            if (ex_hit) begin
                if (Br_Detected) begin
                    target_reg[ex_idx][ex_hit_way] <= PC_ALU;
                end
`ifdef BTB_2BIT_COUNTER_EN
                if (Br_Detected) begin
                    if (ctr_reg[ex_idx][ex_hit_way] != 2'd3)
                        ctr_reg[ex_idx][ex_hit_way] <= ctr_reg[ex_idx][ex_hit_way] + 2'd1;
                end else begin
                    if (ctr_reg[ex_idx][ex_hit_way] != 2'd0)
                        ctr_reg[ex_idx][ex_hit_way] <= ctr_reg[ex_idx][ex_hit_way] - 2'd1;
                end
`else
                if (!Br_Detected) begin
                    valid_reg[ex_idx][ex_hit_way] <= 1'b0;
                end
`endif
            end else if (Br_Detected) begin
                valid_reg[ex_idx][victim_way]  <= 1'b1;
                tag_reg[ex_idx][victim_way]    <= ex_tag;
                target_reg[ex_idx][victim_way] <= PC_ALU;
`ifdef BTB_2BIT_COUNTER_EN
                ctr_reg[ex_idx][victim_way]    <= 2'd2;
`endif
            end
        end
    end

    // True-LRU ages: each set keeps a permutation of 0..WAYS-1
    generate
        if (WAYS > 1) begin : g_age
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_reg[s][w] <= AGE_W'(w);
                        end
                    end
                end else if (touch_en) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == touched_way)
                            age_reg[ex_idx][w] <= '0;
                        else if (age_reg[ex_idx][w] < touched_age)
                            age_reg[ex_idx][w] <= age_reg[ex_idx][w] + AGE_W'(1);
                    end
                end
            end
        end else begin : g_no_age
            // Single way: the only way is always both MRU and victim
            always_comb begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_reg[s][w] = '0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_branch_target_assoc.sv
// Testbench for branch_target_assoc (default parameters: 32-bit, 8 sets, 2 ways).
// Each cycle applies one vector, queues the expected lookup result and checks it
// half a cycle later; the update in the vector takes effect at the next edge.
module tb_branch_target_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, PC_Ex, PC_ALU;
    logic        Br_Update, Br_Detected;
    logic        Hit, Pred_Taken;
    logic [31:0] Target_Add;

    always #5 clk = ~clk;

    branch_target_assoc dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .PC_Ex       (PC_Ex),
        .PC_ALU      (PC_ALU),
        .Br_Update   (Br_Update),
        .Br_Detected (Br_Detected),
        .Hit         (Hit),
        .Pred_Taken  (Pred_Taken),
        .Target_Add  (Target_Add)
    );

    typedef struct {
        logic        r, u, t;
        logic [31:0] pex, palu, pc;
        logic        eh, ept;
        logic [31:0] etg;
        string       nm;
    } vec_t;

    typedef struct {
        logic        eh, ept;
        logic [31:0] etg;
        string       nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] A  = 32'h1234_0000;
    localparam logic [31:0] B  = 32'h5678_0000;
    localparam logic [31:0] C  = 32'h9ABC_0000;
    localparam logic [31:0] D  = 32'h0000_0100;
    localparam logic [31:0] E  = 32'h0000_0008;
    localparam logic [31:0] T1 = 32'h4444_4440;
    localparam logic [31:0] T2 = 32'h5555_5550;
    localparam logic [31:0] T3 = 32'h6666_6660;
    localparam logic [31:0] TE = 32'h7777_7770;

    function automatic vec_t mk(input logic r, input logic u, input logic t,
                                input logic [31:0] pex, input logic [31:0] palu,
                                input logic [31:0] pc, input logic eh, input logic ept,
                                input logic [31:0] etg, input string nm);
        vec_t v;
        v.r = r; v.u = u; v.t = t; v.pex = pex; v.palu = palu; v.pc = pc;
        v.eh = eh; v.ept = ept; v.etg = etg; v.nm = nm;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        rst = v.r; Br_Update = v.u; Br_Detected = v.t;
        PC_Ex = v.pex; PC_ALU = v.palu; PC = v.pc;
        e.eh = v.eh; e.ept = v.ept; e.etg = v.etg; e.nm = v.nm;
        sb.push_back(e);
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", v.nm);
        end else begin
            g = sb.pop_front();
            if (Hit !== g.eh || Pred_Taken !== g.ept || Target_Add !== g.etg) begin
                bad++;
                $display("FAIL %s: got hit=%0b pt=%0b tgt=%h, want hit=%0b pt=%0b tgt=%h",
                         g.nm, Hit, Pred_Taken, Target_Add, g.eh, g.ept, g.etg);
            end else begin
                $display("ok   %s: hit=%0b pt=%0b tgt=%h", g.nm, Hit, Pred_Taken, Target_Add);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Br_Update = 1'b0; Br_Detected = 1'b0;
        PC = '0; PC_Ex = '0; PC_ALU = '0;

        // r u t  PC_Ex  PC_ALU          PC     hit pt tgt
        tbl.push_back(mk(1,0,0, 0, 0,            A,   0,0, A+4,            "reset_outputs"));
        tbl.push_back(mk(0,0,0, 0, 0,            A,   0,0, A+4,            "post_reset_miss"));
        tbl.push_back(mk(0,1,1, A, 32'hFFFF_AAAA, A,  0,0, A+4,            "no_bypass"));
        tbl.push_back(mk(0,0,0, 0, 0,            A,   1,1, 32'hFFFF_AAAA,  "alloc_visible"));
        tbl.push_back(mk(0,1,1, B, 32'h1111_1110, B,  0,0, B+4,            "alloc_b_pre"));
        tbl.push_back(mk(0,1,1, C, 32'h2222_2220, A,  1,1, 32'hFFFF_AAAA,  "alloc_c_pre"));
        tbl.push_back(mk(0,0,0, 0, 0,            A,   0,0, A+4,            "a_evicted"));
        tbl.push_back(mk(0,0,0, 0, 0,            B,   1,1, 32'h1111_1110,  "b_hit"));
        tbl.push_back(mk(0,0,0, 0, 0,            C,   1,1, 32'h2222_2220,  "c_hit"));
        tbl.push_back(mk(0,1,1, C, 32'hAAAA_AAAA, C,  1,1, 32'h2222_2220,  "retarget_pre"));
        tbl.push_back(mk(0,0,0, 0, 0,            C,   1,1, 32'hAAAA_AAAA,  "retarget_post"));
        tbl.push_back(mk(0,0,0, 0, 0,            B,   1,1, 32'h1111_1110,  "retarget_no_alloc"));
        tbl.push_back(mk(1,1,1, D, 32'h3333_3330, C,  0,0, C+4,            "rst_forced"));
        tbl.push_back(mk(0,0,0, 0, 0,            C,   0,0, C+4,            "rst_c_miss"));
        tbl.push_back(mk(0,0,0, 0, 0,            B,   0,0, B+4,            "rst_b_miss"));
        tbl.push_back(mk(0,0,0, 0, 0,            D,   0,0, D+4,            "rst_update_dropped"));
        tbl.push_back(mk(0,1,1, A, T1,           0,   0,0, 32'h4,          "lru_alloc_a"));
        tbl.push_back(mk(0,1,1, B, T2,           A,   1,1, T1,             "lru_alloc_b"));
        tbl.push_back(mk(0,1,1, A, T1,           B,   1,1, T2,             "lru_touch_a"));
        tbl.push_back(mk(0,1,1, C, T3,           C,   0,0, C+4,            "lru_alloc_c"));
        tbl.push_back(mk(0,0,0, 0, 0,            B,   0,0, B+4,            "lru_b_evicted"));
        tbl.push_back(mk(0,0,0, 0, 0,            A,   1,1, T1,             "lru_a_kept"));
        tbl.push_back(mk(0,0,0, 0, 0,            C,   1,1, T3,             "lru_c_hit"));
        tbl.push_back(mk(0,0,0, 0, 0,            C|32'h3, 1,1, T3,         "low_bits_ignored"));
        tbl.push_back(mk(0,0,0, 0, 0,            C|32'h4, 0,0, C+8,        "other_set_miss"));
        tbl.push_back(mk(0,1,0, 32'hC, 32'h1,    32'hC, 0,0, 32'h10,       "nt_miss_pre"));
        tbl.push_back(mk(0,0,0, 0, 0,            32'hC, 0,0, 32'h10,       "nt_miss_nochange"));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Direction handling on a fresh entry in set 2
        apply(mk(0,1,1, E, TE, E, 0,0, E+4, "e_alloc_pre"));
`ifdef BTB_2BIT_COUNTER_EN
        apply(mk(0,1,0, E, 0,  E, 1,1, TE, "ctr2_nt"));
        apply(mk(0,1,0, E, 0,  E, 1,0, TE, "ctr1_nt"));
        apply(mk(0,1,0, E, 0,  E, 1,0, TE, "ctr0_nt_sat"));
        apply(mk(0,1,1, E, TE, E, 1,0, TE, "ctr0_t"));
        apply(mk(0,1,1, E, TE, E, 1,0, TE, "ctr1_t"));
        apply(mk(0,0,0, 0, 0,  E, 1,1, TE, "ctr2_taken_again"));
`else
        apply(mk(0,1,0, E, 0,  E, 1,1, TE,  "nt_hit_pre"));
        apply(mk(0,1,0, E, 0,  E, 0,0, E+4, "nt_invalidated"));
        apply(mk(0,1,1, E, TE, E, 0,0, E+4, "realloc_pre"));
        apply(mk(0,0,0, 0, 0,  E, 1,1, TE,  "realloc_hit"));
`endif
        // Neighbouring set 0 entries are unaffected by set 2 activity
        apply(mk(0,0,0, 0, 0, A, 1,1, T1, "set0_untouched"));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
